// File: rtl/bus_responder_if.sv
// ---------------------------------------------------------------------------
// bus_responder_if
// Single-beat IDLE/BBUSY/BWAIT/BFRER bus between one initiator and one
// responder.
//   req    initiator -> responder  request level, held until ack
//   we     initiator -> responder  1 = write, 0 = read
//   addr   initiator -> responder  register address (AW bits)
//   wdata  initiator -> responder  write data (DW bits)
//   ack    responder -> initiator  one-cycle completion strobe
//   err    responder -> initiator  error flag, only valid with ack
//   rdata  responder -> initiator  read data, valid with ack and err=0
//   busy   responder -> initiator  transaction in progress
//   state  responder -> initiator  one-hot responder state for debug
// ---------------------------------------------------------------------------
interface bus_responder_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic          err;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [3:0]    state;

    modport master (
        output req, we, addr, wdata,
        input  ack, err, rdata, busy, state
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, err, rdata, busy, state
    );
endinterface

// File: rtl/bus_responder.sv
// ---------------------------------------------------------------------------
// bus_responder
// Single-beat bus target in front of a DEPTH x DW register file. Good
// accesses complete after WAIT_CYC wait states; addresses >= DEPTH complete
// one cycle after the request with an error response.
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (clears state, counter, memory)
//   bus    slave side of bus_responder_if
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | 0001  waiting for req; latches command when req=1
// BWAIT  | 0100  counting wait states on the latched command
// BBUSY  | 0010  good completion: ack=1, err=0; write lands on exit
// BFRER  | 1000  error completion: ack=1, err=1, rdata cleared
// ---------------------------------------------------------------------------
module bus_responder #(
    parameter int DW       = 8,
    parameter int AW       = 4,
    parameter int DEPTH    = 16,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_responder_if.slave    bus
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_BBUSY = 4'b0010,
        S_BWAIT = 4'b0100,
        S_BFRER = 4'b1000
    } state_t;

    localparam logic [3:0] WAIT_LD   = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
    // With DEPTH = 2^AW every address is implemented, so the error path is
    // tied off rather than compared against a value that does not fit in AW.
    localparam bit         HAS_ERR   = (DEPTH < (1 << AW));
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] mem [DEPTH];
    logic          addr_bad;

    assign addr_bad = HAS_ERR && ({1'b0, bus.addr} >= DEPTH_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    if (addr_bad) begin
                        state_d = S_BFRER;
                    end else if (WAIT_CYC > 0) begin
                        state_d = S_BWAIT;
                    end else begin
                        state_d = S_BBUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BWAIT: state_d = (cnt_q == 4'd0) ? S_BBUSY : S_BWAIT;
            S_BBUSY: state_d = S_IDLE;
            S_BFRER: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs come straight from the state flops.
    assign bus.ack   = (state_q == S_BBUSY) || (state_q == S_BFRER);
    assign bus.err   = (state_q == S_BFRER);
    assign bus.busy  = ~state_q[0];
    assign bus.state = state_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= WAIT_LD;
                        if (addr_bad) begin
                            rdata_q <= '0;
                        end else if ((WAIT_CYC == 0) && !bus.we) begin
                            // Zero wait states: BBUSY is entered directly,
                            // so the read uses the live address.
                            rdata_q <= mem[bus.addr];
                        end
                    end
                end
                S_BWAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!we_q) begin
                        rdata_q <= mem[addr_q];
                    end
                end
                S_BBUSY: begin
                    if (we_q) begin
                        mem[addr_q] <= wdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_responder
// Two responders side by side: dut0 with DEPTH=12, WAIT_CYC=2 and dut1 with
// DEPTH=16, WAIT_CYC=0. A transaction-level model predicts every output on
// every cycle; directed transactions additionally check hand-computed
// latencies and read data.
// ---------------------------------------------------------------------------
module tb_bus_responder;

    logic       clk = 1'b0;
    logic [1:0] rst_n;

    logic       req_i   [2];
    logic       we_i    [2];
    logic [3:0] addr_i  [2];
    logic [7:0] wdata_i [2];

    logic       ack_o   [2];
    logic       err_o   [2];
    logic       busy_o  [2];
    logic [3:0] state_o [2];
    logic [7:0] rdata_o [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_ack_cyc;
    bit saw_wait1 = 1'b0;

    bus_responder_if #(.DW(8), .AW(4)) bus0 ();
    bus_responder_if #(.DW(8), .AW(4)) bus1 ();

    assign bus0.req = req_i[0];  assign bus0.we = we_i[0];
    assign bus0.addr = addr_i[0]; assign bus0.wdata = wdata_i[0];
    assign bus1.req = req_i[1];  assign bus1.we = we_i[1];
    assign bus1.addr = addr_i[1]; assign bus1.wdata = wdata_i[1];

    assign ack_o[0] = bus0.ack;   assign err_o[0] = bus0.err;
    assign busy_o[0] = bus0.busy; assign state_o[0] = bus0.state;
    assign rdata_o[0] = bus0.rdata;
    assign ack_o[1] = bus1.ack;   assign err_o[1] = bus1.err;
    assign busy_o[1] = bus1.busy; assign state_o[1] = bus1.state;
    assign rdata_o[1] = bus1.rdata;

    bus_responder #(.DW(8), .AW(4), .DEPTH(12), .WAIT_CYC(2)) dut0 (
        .clk   (clk),
        .rst_n (rst_n[0]),
        .bus   (bus0)
    );

    bus_responder #(.DW(8), .AW(4), .DEPTH(16), .WAIT_CYC(0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n[1]),
        .bus   (bus1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------
    // Transaction-level model: where the responder is in its schedule
    // (idle / waiting n more cycles / completing) plus a plain memory.
    // ------------------------------------------------------------------
    bit         m_wait [2];
    int         m_left [2];
    bit         m_ack  [2];
    bit         m_err  [2];
    bit         m_we   [2];
    logic [3:0] m_addr [2];
    logic [7:0] m_wd   [2];
    logic [7:0] m_rd   [2];
    logic [7:0] m_mem  [2][16];

    function automatic int depth_of(int k);
        return (k == 0) ? 12 : 16;
    endfunction

    function automatic int waits_of(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic model_reset(int k);
        m_wait[k] = 0; m_left[k] = 0; m_ack[k] = 0; m_err[k] = 0;
        m_we[k] = 0; m_addr[k] = '0; m_wd[k] = '0; m_rd[k] = '0;
        for (int i = 0; i < 16; i++) m_mem[k][i] = '0;
    endtask

    task automatic model_step(int k);
        if (m_ack[k]) begin
            if (!m_err[k] && m_we[k]) m_mem[k][m_addr[k]] = m_wd[k];
            m_ack[k] = 0;
        end else if (m_wait[k]) begin
            m_left[k] = m_left[k] - 1;
            if (m_left[k] == 0) begin
                m_wait[k] = 0;
                m_ack[k]  = 1;
                m_err[k]  = 0;
                if (!m_we[k]) m_rd[k] = m_mem[k][m_addr[k]];
            end
        end else if (req_i[k]) begin
            m_we[k]   = we_i[k];
            m_addr[k] = addr_i[k];
            m_wd[k]   = wdata_i[k];
            if (int'(addr_i[k]) >= depth_of(k)) begin
                m_ack[k] = 1;
                m_err[k] = 1;
                m_rd[k]  = '0;
            end else if (waits_of(k) > 0) begin
                m_wait[k] = 1;
                m_left[k] = waits_of(k);
            end else begin
                m_ack[k] = 1;
                m_err[k] = 0;
                if (!we_i[k]) m_rd[k] = m_mem[k][addr_i[k]];
            end
        end
    endtask

    function automatic logic [3:0] model_state(int k);
        if (m_ack[k]) return m_err[k] ? 4'b1000 : 4'b0010;
        if (m_wait[k]) return 4'b0100;
        return 4'b0001;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst_n[k]) model_step(k);
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n[k]) model_reset(k);
            chk($sformatf("dut%0d.state", k), 32'(state_o[k]), 32'(model_state(k)));
            chk($sformatf("dut%0d.ack", k), 32'(ack_o[k]), 32'(m_ack[k]));
            chk($sformatf("dut%0d.err", k), 32'(err_o[k]), 32'(m_ack[k] && m_err[k]));
            chk($sformatf("dut%0d.busy", k), 32'(busy_o[k]), 32'(m_ack[k] || m_wait[k]));
            chk($sformatf("dut%0d.rdata", k), 32'(rdata_o[k]), 32'(m_rd[k]));
        end
        if (state_o[1] == 4'b0100) saw_wait1 = 1'b1;
    end

    // ------------------------------------------------------------------
    // Directed transaction: called just after a rising edge (cycle 0).
    // ------------------------------------------------------------------
    task automatic do_txn(input int k, input bit w, input logic [3:0] a,
                          input logic [7:0] d, input bit exp_err,
                          input logic [7:0] exp_rd, input int exp_lat,
                          input bit keep_req);
        int lat = 0;
        bit got = 0;
        req_i[k] = 1'b1; we_i[k] = w; addr_i[k] = a; wdata_i[k] = d;
        while (!got && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ack_o[k]) got = 1;
        end
        chk($sformatf("dut%0d.txn_ack_seen a=%0d", k, a), 32'(got), 32'd1);
        chk($sformatf("dut%0d.txn_latency a=%0d", k, a), 32'(lat), 32'(exp_lat));
        chk($sformatf("dut%0d.txn_err a=%0d", k, a), 32'(err_o[k]), 32'(exp_err));
        if (!w || exp_err)
            chk($sformatf("dut%0d.txn_rdata a=%0d", k, a), 32'(rdata_o[k]), 32'(exp_rd));
        last_ack_cyc = cyc;
        @(posedge clk);
        #1;
        if (!keep_req) req_i[k] = 1'b0;
    endtask

    initial begin
        int first_ack;
        rst_n = 2'b00;
        for (int k = 0; k < 2; k++) begin
            req_i[k] = 1'b1; we_i[k] = 1'b0; addr_i[k] = 4'd2; wdata_i[k] = 8'h00;
        end

        // Reset held with a live request: outputs stay at reset values.
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst dut%0d.state", k), 32'(state_o[k]), 32'h1);
            chk($sformatf("rst dut%0d.ack", k), 32'(ack_o[k]), 32'h0);
            chk($sformatf("rst dut%0d.busy", k), 32'(busy_o[k]), 32'h0);
            chk($sformatf("rst dut%0d.rdata", k), 32'(rdata_o[k]), 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 2'b11;
        req_i[0] = 1'b0; req_i[1] = 1'b0;

        for (int a = 0; a < 16; a++) begin
            do_txn(0, 1'b0, 4'(a), 8'h00, (a >= 12), 8'h00, (a >= 12) ? 1 : 3, 1'b0);
            do_txn(1, 1'b0, 4'(a), 8'h00, 1'b0, 8'h00, 1, 1'b0);
        end

        // Write then read back with two wait states.
        do_txn(0, 1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, 3, 1'b0);
        do_txn(0, 1'b0, 4'd3, 8'h00, 1'b0, 8'hA5, 3, 1'b0);

        // Out-of-range accesses on DEPTH=12.
        do_txn(0, 1'b1, 4'd11, 8'h77, 1'b0, 8'h00, 3, 1'b0);
        do_txn(0, 1'b0, 4'd13, 8'h00, 1'b1, 8'h00, 1, 1'b0);
        do_txn(0, 1'b1, 4'd12, 8'hFF, 1'b1, 8'h00, 1, 1'b0);
        do_txn(0, 1'b0, 4'd11, 8'h00, 1'b0, 8'h77, 3, 1'b0);

        // Back-to-back with req held high across the ack edge.
        do_txn(0, 1'b1, 4'd1, 8'h11, 1'b0, 8'h00, 3, 1'b1);
        first_ack = last_ack_cyc;
        do_txn(0, 1'b0, 4'd1, 8'h00, 1'b0, 8'h11, 3, 1'b0);
        chk("b2b ack spacing", 32'(last_ack_cyc - first_ack), 32'd4);

        // Reset pulse during the first wait cycle aborts the write.
        req_i[0] = 1'b1; we_i[0] = 1'b1; addr_i[0] = 4'd4; wdata_i[0] = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        chk("abort in BWAIT", 32'(state_o[0]), 32'h4);
        #1;
        rst_n[0] = 1'b0;
        req_i[0] = 1'b0;
        @(negedge clk);
        chk("abort state", 32'(state_o[0]), 32'h1);
        chk("abort ack", 32'(ack_o[0]), 32'h0);
        @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        do_txn(0, 1'b0, 4'd4, 8'h00, 1'b0, 8'h00, 3, 1'b0);
        do_txn(0, 1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 3, 1'b0);

        // Zero wait states, including the top address on a full-depth map.
        do_txn(1, 1'b1, 4'd0, 8'h3C, 1'b0, 8'h00, 1, 1'b0);
        do_txn(1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h3C, 1, 1'b0);
        do_txn(1, 1'b1, 4'd15, 8'hC3, 1'b0, 8'h00, 1, 1'b1);
        do_txn(1, 1'b0, 4'd15, 8'h00, 1'b0, 8'hC3, 1, 1'b0);
        chk("dut1 never in BWAIT", 32'(saw_wait1), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
# bus_responder

Single-beat bus responder (target) that answers the initiator side of the team's IDLE/BBUSY/BWAIT/BFRER bus protocol. It accepts read/write requests against a local register file and inserts a fixed number of wait states. Out-of-range addresses get an error response. The FSM is one-hot using the same state encoding bit positions as the initiator, and the state vector is exported for debug and for cross-checking in benches.

## Interface
Parameters:
- DW, 8, data width
- AW, 4, address width
- DEPTH, 16, implemented registers; addresses >= DEPTH are errors; 1..2^AW
- WAIT_CYC, 2, wait states per good access; 0..15

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request, level, held by initiator until ack
- we  in  1  1 = write, 0 = read; valid with req
- addr  in  AW  register address; valid with req
- wdata  in  DW  write data; valid with req
- ack  out  1  completion strobe, one cycle per transaction
- err  out  1  error flag, only with ack
- rdata  out  DW  read data, valid while ack and err=0
- busy  out  1  transaction in progress (state != IDLE)
- state  out  4  one-hot FSM state: bit0 IDLE, bit1 BBUSY, bit2 BWAIT, bit3 BFRER

## Operation
- The state register is a flop.
- ack, err and busy are decoded from the state register only, so they are glitch-free.
- IDLE (0001): the responder samples req.
  - On req=1 it latches we, addr and wdata.
  - If addr >= DEPTH, next state is BFRER.
  - Else if WAIT_CYC > 0, next state is BWAIT and the wait counter loads WAIT_CYC-1.
  - Else next state is BBUSY.
- BWAIT (0100): the counter decrements each cycle. When it reaches 0, next state is BBUSY. req, addr and wdata are ignored in this state (latched copies are used).
- BBUSY (0010):
  - ack=1, err=0.
  - Read: rdata is loaded from mem[latched addr] on the edge entering BBUSY.
  - Write: mem[latched addr] is written on the edge leaving BBUSY. rdata is unchanged.
  - Next state is always IDLE.
- BFRER (1000):
  - ack=1, err=1.
  - rdata is loaded with 0 on entry.
  - No memory write occurs.
  - Next state is IDLE.
- Any state vector that is not exactly one-hot returns to IDLE on the next edge with no side effects.
- busy = ~state[0].
- The memory is DEPTH x DW with a single port. It is written only in BBUSY.
- rdata holds its value between completions.
- The address comparison is unsigned, at AW width. When DEPTH = 2^AW, no error path is reachable.

## Timing
Cycle 0 is the IDLE cycle in which req=1 is sampled.
- Good access: BWAIT occupies cycles 1..WAIT_CYC, and BBUSY with ack occupies cycle WAIT_CYC+1. Request-to-ack latency is WAIT_CYC+1 cycles.
- Error: BFRER with ack and err in cycle 1, regardless of WAIT_CYC.
- Handshake: the initiator samples ack on the rising edge that ends the ack cycle. On that same edge it drops req or presents a new command.
- Back-to-back: cycle WAIT_CYC+2 is IDLE. If req is high there, it is a new transaction. Minimum ack spacing is WAIT_CYC+2 cycles.
- req=0 in IDLE: stay in IDLE, and all outputs hold.
- Reset (asynchronous, any state):
  - Outputs: state=0001, ack=0, err=0, busy=0, rdata=0.
  - Internal: wait counter=0, all memory entries=0.
- Reset during BWAIT or BBUSY aborts the transaction with no write and no ack. The first legal sample after release is the first rising edge with rst_n=1.

## Test plan
1. Reset with req=1 and addr=2 held: the response holds state=0001, ack=0, err=0, busy=0 and rdata=0 while rst_n=0. After release, reads of addrs 0..15 all return 0.
2. WAIT_CYC=2, write addr 3 with 0xA5: the response is busy=1 in cycles 1-3, state=0100 in cycles 1-2, then state=0010 with ack=1 and err=0 in cycle 3. A following read of addr 3 returns ack in its cycle 3 with rdata=0xA5.
3. DEPTH=12, read addr 13: the response is ack=1, err=1, state=1000 and rdata=0x00 in cycle 1. Then write 0xFF to addr 12 also gets err=1, and a read of addr 11 still returns its previous value.
4. Back-to-back with WAIT_CYC=2, req held high: write addr 1 with 0x11, then read addr 1 presented on the ack edge. Acks appear in cycles 3 and 7, and the second returns rdata=0x11.
5. Write 0x5A to addr 4 with rst_n pulsed low during BWAIT cycle 1: there is no ack, state=0001 after reset, and a subsequent read of addr 4 returns 0x00.
6. WAIT_CYC=0, read addr 0 after writing 0x3C to it: the response is ack in cycle 1 with rdata=0x3C, and state never shows 0100.
